// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and a one-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt saturating perf counters.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DATA_N = 4
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                     Clk,
  input  logic                     Clrn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [DATA_N*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [DATA_N*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  localparam int unsigned PayW = DATA_N * DATA_W;

  // Encoding is {skid_valid, main_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b01,
    StSkid  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [PayW-1:0]     main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [PayW-1:0]     skid_data_q, skid_data_d;
  logic                main_valid;
  logic                skid_valid;
  logic                in_fire;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign in_fire    = in_valid & in_ready;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Anything accepted this cycle is dropped; payloads are left untouched.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d     = StFull;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        StFull: begin
          if (in_fire && out_ready) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = StSkid;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (out_ready) begin
            state_d     = StFull;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!main_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
